// File: rtl/cacheline_mem_responder.sv
// Memory-side responder for cacheline fills and evictions.
// Backing store, in-order read queue and fixed-latency response FSM.
module cacheline_mem_responder #(
  parameter int LINES_LOG2 = 10,
  parameter int LATENCY    = 5,
  parameter int FIFO_LOG2  = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [31:0]  addr_in,
  input  logic [127:0] data_in,
  input  logic         rden,
  input  logic         wren,
  output logic [127:0] data_out,
  output logic         data_out_valid,
  output logic         req_ready,
  output logic         overflow
);

  localparam int LINES = 1 << LINES_LOG2;
  localparam int DEPTH = 1 << FIFO_LOG2;
  localparam logic [3:0] LOAD_IDLE =
    4'((LATENCY > 2) ? LATENCY - 3 : 0);
  localparam logic [3:0] LOAD_RESP = 4'(LATENCY - 2);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  typedef logic [LINES_LOG2-1:0] idx_t;

  idx_t idx;
  assign idx = addr_in[LINES_LOG2+3:4];

  logic unused_addr;
  assign unused_addr =
    ^{addr_in[31:LINES_LOG2+4], addr_in[3:0]};

  function automatic logic [127:0] init_line(
    input idx_t i
  );
    logic [127:0] res;
    res = '0;
    for (int k = 0; k < 4; k++) begin
      res[32*k +: 32] = 32'({i, 2'(k), 2'b00});
    end
    return res;
  endfunction

  // Lines never written read back their power-up pattern.
  logic [127:0]     mem [LINES];
  logic [LINES-1:0] written = '0;

  always_ff @(posedge clk) begin
    if (wren) begin
      mem[idx]     <= data_in;
      written[idx] <= 1'b1;
    end
  end

  idx_t                 fifo [DEPTH];
  logic [FIFO_LOG2-1:0] wp;
  logic [FIFO_LOG2-1:0] rp;
  logic [FIFO_LOG2:0]   count;
  logic                 push;
  logic                 pop;

  assign req_ready = (count != (FIFO_LOG2+1)'(DEPTH));
  assign push      = rden && req_ready;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo[wp] <= idx;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
      count <= count
             + {{FIFO_LOG2{1'b0}}, push}
             - {{FIFO_LOG2{1'b0}}, pop};
    end
  end

  state_t       state;
  state_t       state_n;
  logic [3:0]   cnt;
  logic [3:0]   cnt_n;
  idx_t         cur_idx;
  logic         respond;
  logic         use_head;
  logic         has_req;

  assign has_req = (count != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_ff @(posedge clk) begin
    if (pop) begin
      cur_idx <= fifo[rp];
    end
  end

  // Respond happens on the edge that enters RESP.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    pop      = 1'b0;
    respond  = 1'b0;
    use_head = 1'b0;
    unique case (state)
      IDLE: begin
        if (has_req) begin
          pop = 1'b1;
          if (LATENCY == 2) begin
            respond  = 1'b1;
            use_head = 1'b1;
            state_n  = RESP;
          end else begin
            cnt_n   = LOAD_IDLE;
            state_n = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          respond = 1'b1;
          state_n = RESP;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      RESP: begin
        if (has_req) begin
          pop     = 1'b1;
          cnt_n   = LOAD_RESP;
          state_n = WAIT;
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  idx_t         rsp_idx;
  logic [127:0] rsp_data;

  // A write landing on the response edge wins.
  always_comb begin
    rsp_idx = use_head ? fifo[rp] : cur_idx;
    if (wren && idx == rsp_idx) begin
      rsp_data = data_in;
    end else if (written[rsp_idx]) begin
      rsp_data = mem[rsp_idx];
    end else begin
      rsp_data = init_line(rsp_idx);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_out       <= '0;
      data_out_valid <= 1'b0;
      overflow       <= 1'b0;
    end else begin
      data_out_valid <= respond;
      if (respond) data_out <= rsp_data;
      if (rden && !req_ready) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cacheline_mem_responder.sv
// Directed bench for cacheline_mem_responder.
// Inputs change and outputs are sampled on the falling edge.
module tb_cacheline_mem_responder;

  logic         clk = 1'b0;
  logic         reset;
  logic [31:0]  addr_in;
  logic [127:0] data_in;
  logic         rden;
  logic         wren;
  logic [127:0] data_out;
  logic         data_out_valid;
  logic         req_ready;
  logic         overflow;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  cacheline_mem_responder dut (
    .clk            (clk),
    .reset          (reset),
    .addr_in        (addr_in),
    .data_in        (data_in),
    .rden           (rden),
    .wren           (wren),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .req_ready      (req_ready),
    .overflow       (overflow)
  );

  localparam logic [127:0] LINE_A =
    128'hDEADBEEF_11111111_22222222_33333333;
  localparam logic [127:0] LINE_L =
    128'hCAFEF00D_01234567_89ABCDEF_FEEDFACE;
  localparam logic [127:0] LINE_M =
    128'h55555555_66666666_77777777_88888888;
  localparam logic [127:0] LINE_N =
    128'h0BADC0DE_A5A5A5A5_5A5A5A5A_12345678;

  task automatic check(
    input string        tag,
    input logic [127:0] got,
    input logic [127:0] exp
  );
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  function automatic logic [127:0] fresh_line(
    input int n
  );
    logic [31:0] b;
    b = 32'(n * 16);
    return {b + 32'd12, b + 32'd8, b + 32'd4, b};
  endfunction

  // Read with an optional write in cycle wcyc.
  task automatic read_line(
    input string        tag,
    input logic [31:0]  a,
    input logic [127:0] exp,
    input int           wcyc,
    input logic [31:0]  wa,
    input logic [127:0] wd
  );
    for (int c = 0; c <= 5; c++) begin
      if (c > 0 && c < 5)
        check({tag, "_early"}, 128'(data_out_valid), 0);
      if (c == 5) begin
        check({tag, "_valid"}, 128'(data_out_valid), 1);
        check({tag, "_data"}, data_out, exp);
      end
      rden    = (c == 0);
      wren    = (c == wcyc);
      addr_in = (c == wcyc) ? wa : a;
      data_in = wd;
      @(negedge clk);
    end
    rden = 1'b0;
    wren = 1'b0;
    check({tag, "_pulse1"}, 128'(data_out_valid), 0);
  endtask

  initial begin
    reset   = 1'b1;
    rden    = 1'b0;
    wren    = 1'b0;
    addr_in = '0;
    data_in = '0;
    repeat (3) @(negedge clk);
    check("rst_data", data_out, 0);
    check("rst_valid", 128'(data_out_valid), 0);
    check("rst_ovf", 128'(overflow), 0);
    check("rst_ready", 128'(req_ready), 1);
    reset = 1'b0;
    @(negedge clk);

    read_line("fill", 32'h120,
      128'h0000012C_00000128_00000124_00000120,
      -1, 0, 0);

    wren    = 1'b1;
    addr_in = 32'h340;
    data_in = LINE_A;
    @(negedge clk);
    wren = 1'b0;
    read_line("wr_rd", 32'h340, LINE_A, -1, 0, 0);

    read_line("alias", 32'h4000, LINE_L,
      1, 32'h0, LINE_L);

    read_line("same", 32'h500, LINE_M,
      0, 32'h500, LINE_M);

    read_line("late_wr", 32'h600, LINE_N,
      4, 32'h600, LINE_N);

    // Six back-to-back reads into a four-deep queue.
    for (int c = 0; c <= 35; c++) begin
      if (c >= 5 && c <= 25 && c % 5 == 0) begin
        check("q_valid", 128'(data_out_valid), 1);
        check("q_data", data_out, fresh_line(c / 5));
      end else begin
        check("q_idle", 128'(data_out_valid), 0);
      end
      if (c <= 5)
        check("q_ready", 128'(req_ready), 128'(c < 5));
      check("q_ovf", 128'(overflow), 128'(c >= 6));
      rden    = (c < 6);
      addr_in = 32'((c + 1) * 16);
      @(negedge clk);
    end

    rden    = 1'b1;
    addr_in = 32'h340;
    @(negedge clk);
    rden = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst2_data", data_out, 0);
    check("rst2_ovf", 128'(overflow), 0);
    check("rst2_ready", 128'(req_ready), 1);
    for (int c = 0; c < 8; c++) begin
      check("rst2_nopulse", 128'(data_out_valid), 0);
      @(negedge clk);
    end

    read_line("keep_a", 32'h340, LINE_A, -1, 0, 0);
    read_line("keep_l", 32'h0, LINE_L, -1, 0, 0);

    for (int c = 0; c < 20; c++) begin
      check("idle_valid", 128'(data_out_valid), 0);
      check("idle_hold", data_out, LINE_L);
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fails);
    $finish;
  end

endmodule
